// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter array: read FSM states and
// the event index assignment used by the core's counter wiring.
package perf_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StResp = 1'b1
  } rd_state_e;

  localparam int unsigned EVT_IFU_VALID     = 0;
  localparam int unsigned EVT_ICACHE_ACCESS = 1;
  localparam int unsigned EVT_ICACHE_HIT    = 2;
  localparam int unsigned EVT_LSU_LOAD      = 3;
  localparam int unsigned EVT_LSU_STORE     = 4;
  localparam int unsigned EVT_LSU_WAIT      = 5;

endpackage

// File: rtl/perf_counter_ch.sv
// One event channel: edge/level qualification, wrapping or saturating counter
// with sticky overflow, and a shadow copy loaded on snap.
module perf_counter_ch import perf_pkg::*; #(
  parameter int unsigned CNT_W    = 48,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             evt_i,
  input  logic             edge_mode_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] shadow_cnt_o,
  output logic             shadow_ovf_o
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             shadow_ovf_q, shadow_ovf_d;
  logic             inc;

  always_comb begin
    inc    = enable_i & ~clear_i & (edge_mode_i ? (evt_i & ~prev_q) : evt_i);
    // prev tracks evt even while disabled so re-enabling never sees a false edge
    prev_d = evt_i;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Shadow takes the pre-update value, so snap+clear keeps the old count
    shadow_d     = snap_i ? cnt_q : shadow_q;
    shadow_ovf_d = snap_i ? ovf_q : shadow_ovf_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      shadow_q     <= '0;
      shadow_ovf_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      shadow_q     <= shadow_d;
      shadow_ovf_q <= shadow_ovf_d;
    end
  end

  assign shadow_cnt_o = shadow_q;
  assign shadow_ovf_o = shadow_ovf_q;

endmodule

// File: rtl/perf_counter_array.sv
// Array of NUM_CH performance counters with snapshot shadows and a
// valid/ready read port returning one shadow value per request.
module perf_counter_array import perf_pkg::*; #(
  parameter  int unsigned NUM_CH   = 8,
  parameter  int unsigned CNT_W    = 48,
  parameter  int unsigned SATURATE = 0,
  localparam int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] evt,
  input  logic [NUM_CH-1:0] edge_mode,
  input  logic              enable,
  input  logic              clear,
  input  logic              snap,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              rd_err
);

  logic [CNT_W-1:0]  shadow_cnt [NUM_CH];
  logic [NUM_CH-1:0] shadow_ovf;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_counter_ch #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .evt_i        (evt[g]),
      .edge_mode_i  (edge_mode[g]),
      .enable_i     (enable),
      .clear_i      (clear),
      .snap_i       (snap),
      .shadow_cnt_o (shadow_cnt[g]),
      .shadow_ovf_o (shadow_ovf[g])
    );
  end

  logic [CNT_W-1:0] sel_data;
  logic             sel_ovf;
  logic             sel_hit;

  // Compare-based mux keeps out-of-range indices from touching the array
  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    sel_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        sel_data = shadow_cnt[i];
        sel_ovf  = shadow_ovf[i];
        sel_hit  = 1'b1;
      end
    end
  end

  rd_state_e        state_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_ovf_q;
  logic             rd_err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_req_valid) begin
            state_q   <= StResp;
            rd_data_q <= sel_data;
            rd_ovf_q  <= sel_ovf;
            rd_err_q  <= ~sel_hit;
          end
        end
        StResp: begin
          if (rd_resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_req_ready  = (state_q == StIdle);
  assign rd_resp_valid = (state_q == StResp);
  assign rd_data       = rd_data_q;
  assign rd_ovf        = rd_ovf_q;
  assign rd_err        = rd_err_q;

endmodule
